// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - load-use / imem-wait stall controller with ID-stage forwarding selects
module pipe_stall_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_wreg,
    input  logic             ex_m2reg,
    input  logic [4:0]       ex_rn,
    input  logic             mem_wreg,
    input  logic             mem_m2reg,
    input  logic [4:0]       mem_rn,
    input  logic             imem_ready,
    output logic             wpcir,
    output logic             id_bubble,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             imem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WC_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, LSTALL, IWAIT} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WC_W-1:0] wait_cnt;
    logic            lu;
    logic            iw;

    assign lu = ex_wreg & ex_m2reg & (ex_rn != 5'd0) &
                ((id_use_rs & (ex_rn == id_rs)) | (id_use_rt & (ex_rn == id_rt)));
    assign iw = ~imem_ready;

    // EX ALU results beat MEM; loads still in EX cannot forward and are covered by lu.
    function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                           input logic ewreg, input logic em2reg,
                                           input logic [4:0] ern,
                                           input logic mwreg, input logic mm2reg,
                                           input logic [4:0] mrn);
        if (ewreg && !em2reg && ern == r && ern != 5'd0)
            return 2'd1;
        else if (mwreg && mrn == r && mrn != 5'd0)
            return mm2reg ? 2'd3 : 2'd2;
        else
            return 2'd0;
    endfunction

    assign fwda = fwd_sel(id_rs, ex_wreg, ex_m2reg, ex_rn, mem_wreg, mem_m2reg, mem_rn);
    assign fwdb = fwd_sel(id_rt, ex_wreg, ex_m2reg, ex_rn, mem_wreg, mem_m2reg, mem_rn);

    always_comb begin
        wpcir     = 1'b0;
        state_nxt = RUN;
        case (state)
            RUN: begin
                if (lu) begin
                    wpcir     = 1'b1;
                    state_nxt = LSTALL;
                end else if (iw) begin
                    wpcir     = 1'b1;
                    state_nxt = IWAIT;
                end
            end
            LSTALL: begin
                if (iw) begin
                    wpcir     = 1'b1;
                    state_nxt = IWAIT;
                end
            end
            IWAIT: begin
                if (iw) begin
                    wpcir     = 1'b1;
                    state_nxt = IWAIT;
                end else if (lu) begin
                    wpcir     = 1'b1;
                    state_nxt = LSTALL;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    assign id_bubble = wpcir;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= RUN;
            wait_cnt     <= '0;
            imem_timeout <= 1'b0;
            stall_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IWAIT && iw) begin
                if (wait_cnt != WC_W'(TIMEOUT))
                    wait_cnt <= wait_cnt + 1'b1;
                if (wait_cnt >= WC_W'(TIMEOUT - 1))
                    imem_timeout <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (wpcir && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed and random checks of pipe_stall_ctrl against a behavioural model
module tb_pipe_stall_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 6;
    localparam int SCNT_MAX = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             resetn;
    logic [4:0]       id_rs, id_rt, ex_rn, mem_rn;
    logic             id_use_rs, id_use_rt, ex_wreg, ex_m2reg, mem_wreg, mem_m2reg, imem_ready;
    logic             wpcir, id_bubble, imem_timeout;
    logic [1:0]       fwda, fwdb;
    logic [CNT_W-1:0] stall_cnt;

    pipe_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock(clock), .resetn(resetn),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn),
        .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn),
        .imem_ready(imem_ready),
        .wpcir(wpcir), .id_bubble(id_bubble), .fwda(fwda), .fwdb(fwdb),
        .imem_timeout(imem_timeout), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model: which kind of stall was taken last cycle, plus plain integer counters.
    bit m_after_load;
    bit m_waiting;
    int m_wait_cycles;
    bit m_tout;
    int m_stalls;

    function automatic bit m_lu();
        return ex_wreg && ex_m2reg && ex_rn != 0 &&
               ((id_use_rs && ex_rn == id_rs) || (id_use_rt && ex_rn == id_rt));
    endfunction

    function automatic bit m_hold();
        bit w = !imem_ready;
        if (m_after_load) return w;
        return m_lu() || w;
    endfunction

    function automatic int m_fwd(input logic [4:0] r);
        if (r == 0) return 0;
        if (ex_wreg && !ex_m2reg && ex_rn == r) return 1;
        if (mem_wreg && mem_rn == r) return mem_m2reg ? 3 : 2;
        return 0;
    endfunction

    task automatic set_idle();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_wreg = 0; ex_m2reg = 0; ex_rn = 0;
        mem_wreg = 0; mem_m2reg = 0; mem_rn = 0;
        imem_ready = 1;
    endtask

    task automatic model_reset();
        m_after_load = 0; m_waiting = 0; m_wait_cycles = 0; m_tout = 0; m_stalls = 0;
    endtask

    // Called at negedge with inputs driven; checks, clocks, updates model, returns at negedge.
    task automatic tick();
        bit h, l, w, was_running;
        #1;
        h = m_hold();
        chk("wpcir", 32'(wpcir), 32'(h));
        chk("id_bubble", 32'(id_bubble), 32'(h));
        if (!h) begin
            chk("fwda", 32'(fwda), 32'(m_fwd(id_rs)));
            chk("fwdb", 32'(fwdb), 32'(m_fwd(id_rt)));
        end
        chk("imem_timeout", 32'(imem_timeout), 32'(m_tout));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
        @(posedge clock);
        l = m_lu();
        w = !imem_ready;
        was_running = !m_after_load && !m_waiting;
        if (h && m_stalls < SCNT_MAX) m_stalls++;
        if (m_waiting && w) begin
            if (m_wait_cycles < TIMEOUT) m_wait_cycles++;
            if (m_wait_cycles >= TIMEOUT) m_tout = 1;
        end else begin
            m_wait_cycles = 0;
        end
        // From RUN a load-use wins; while waiting the memory wins; after a load bubble lu is stale.
        if (was_running) begin
            m_after_load = l;
            m_waiting    = !l && w;
        end else if (m_waiting) begin
            m_after_load = !w && l;
            m_waiting    = w;
        end else begin
            m_after_load = 0;
            m_waiting    = w;
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        set_idle();
        resetn = 0;
        @(negedge clock);
        @(negedge clock);
        model_reset();
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_timeout", 32'(imem_timeout), 32'd0);
        chk("rst_wpcir", 32'(wpcir), 32'd0);
        resetn = 1;
    endtask

    initial begin
        set_idle();
        resetn = 0;
        model_reset();
        do_reset();

        // Load-use: one bubble then forward load data from MEM.
        ex_wreg = 1; ex_m2reg = 1; ex_rn = 3; id_rs = 3; id_use_rs = 1;
        #1;
        chk("lu_wpcir", 32'(wpcir), 32'd1);
        chk("lu_bubble", 32'(id_bubble), 32'd1);
        tick();
        ex_wreg = 0; ex_m2reg = 0; ex_rn = 0;
        mem_wreg = 1; mem_m2reg = 1; mem_rn = 3;
        #1;
        chk("lu_release", 32'(wpcir), 32'd0);
        chk("lu_fwda", 32'(fwda), 32'd3);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        tick();

        // Forwarding priority and register 0.
        set_idle();
        ex_wreg = 1; ex_rn = 5; mem_wreg = 1; mem_rn = 5; id_rt = 5; id_use_rt = 1;
        #1; chk("fwd_ex_prio", 32'(fwdb), 32'd1);
        tick();
        ex_wreg = 0;
        #1; chk("fwd_mem_alu", 32'(fwdb), 32'd2);
        tick();
        set_idle();
        ex_wreg = 1; ex_rn = 0; mem_wreg = 1; mem_rn = 0; id_rs = 0; id_use_rs = 1;
        #1; chk("fwd_r0", 32'(fwda), 32'd0);
        tick();

        // Memory wait of 3 cycles.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            imem_ready = 0;
            #1; chk("iw_hold", 32'(wpcir), 32'd1);
            tick();
        end
        imem_ready = 1;
        #1;
        chk("iw_release", 32'(wpcir), 32'd0);
        chk("iw_stall_cnt", 32'(stall_cnt), 32'd3);
        chk("iw_no_timeout", 32'(imem_timeout), 32'd0);
        tick();

        // Timeout: ready low for 6 cycles (1 entry cycle + 5 IWAIT cycles).
        do_reset();
        imem_ready = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (i == 4) chk("to_not_yet", 32'(imem_timeout), 32'd0);
            if (i == 5) chk("to_set", 32'(imem_timeout), 32'd1);
            tick();
        end
        imem_ready = 1;
        tick();
        #1; chk("to_sticky", 32'(imem_timeout), 32'd1);

        // Simultaneous lu and wait: LSTALL then IWAIT, held until ready.
        do_reset();
        ex_wreg = 1; ex_m2reg = 1; ex_rn = 7; id_rt = 7; id_use_rt = 1; imem_ready = 0;
        tick();
        ex_wreg = 0; ex_m2reg = 0; mem_wreg = 1; mem_m2reg = 1; mem_rn = 7;
        for (int i = 0; i < 3; i++) begin
            #1; chk("sim_hold", 32'(wpcir), 32'd1);
            tick();
        end
        imem_ready = 1;
        #1; chk("sim_release", 32'(wpcir), 32'd0);
        tick();

        // Reset mid-IWAIT, asynchronous.
        imem_ready = 0;
        for (int i = 0; i < 7; i++) tick();
        #2;
        resetn = 0;
        #1;
        chk("arst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("arst_timeout", 32'(imem_timeout), 32'd0);
        set_idle();
        #1; chk("arst_wpcir", 32'(wpcir), 32'd0);
        @(negedge clock);
        model_reset();
        resetn = 1;

        // Long wait saturates stall_cnt.
        imem_ready = 0;
        for (int i = 0; i < SCNT_MAX + 5; i++) tick();
        #1; chk("scnt_sat", 32'(stall_cnt), 32'(SCNT_MAX));
        set_idle();
        tick();

        // Random traffic on a small register set to make hazards frequent.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            id_rs      = 5'($urandom_range(0, 3));
            id_rt      = 5'($urandom_range(0, 3));
            id_use_rs  = 1'($urandom_range(0, 1));
            id_use_rt  = 1'($urandom_range(0, 1));
            ex_wreg    = 1'($urandom_range(0, 1));
            ex_m2reg   = 1'($urandom_range(0, 1));
            ex_rn      = 5'($urandom_range(0, 3));
            mem_wreg   = 1'($urandom_range(0, 1));
            mem_m2reg  = 1'($urandom_range(0, 1));
            mem_rn     = 5'($urandom_range(0, 3));
            imem_ready = ($urandom_range(0, 3) != 0);
            if (i % 150 == 149) do_reset();
            else tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
